// File: rtl/td4x_core.sv
// td4x_core: parametrised TD4 ISA core with program RAM and run control.
// Optional breakpoint support is enabled by defining TD4X_BREAKPOINT_EN.
module td4x_core #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [3:0]        prog_op,
    input  logic [DATA_W-1:0] prog_imm,
    input  logic              prog_we,
    output logic [3:0]        rd_op,
    output logic [DATA_W-1:0] rd_imm,
    input  logic              start,
    input  logic              step,
    input  logic              stop,
    input  logic              clr,
    input  logic [DATA_W-1:0] in_port,
    output logic [DATA_W-1:0] out_port,
    output logic [DATA_W-1:0] reg_a,
    output logic [DATA_W-1:0] reg_b,
    output logic [ADDR_W-1:0] pc,
    output logic              carry,
    output logic [1:0]        run_state
`ifdef TD4X_BREAKPOINT_EN
    ,
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic              bp_valid
`endif
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10,
        HALT = 2'b11
    } state_t;

    state_t state, state_n;

    logic [DATA_W+3:0] ram [DEPTH];
    logic [3:0]        op;
    logic [DATA_W-1:0] imm;
    logic [ADDR_W-1:0] target;
    logic [DATA_W:0]   sum_a, sum_b;
    logic [DATA_W-1:0] a_n, b_n, out_n;
    logic [ADDR_W-1:0] pc_n;
    logic              c_n, jump;
    logic              exec, clr_now, bp_hit, halt_cond;
    logic              exec_mode, load_we;

    assign {imm, op}       = ram[pc];
    assign {rd_imm, rd_op} = ram[prog_addr];
    assign run_state       = state;
    assign exec_mode       = mode[1];
    assign load_we         = (mode == 2'b00) && prog_we;

    // Jump target is the immediate zero-extended or truncated to ADDR_W.
    if (ADDR_W <= DATA_W) begin : g_trunc
        assign target = imm[ADDR_W-1:0];
    end else begin : g_ext
        assign target = {{(ADDR_W-DATA_W){1'b0}}, imm};
    end

`ifdef TD4X_BREAKPOINT_EN
    assign bp_hit = (state == RUN) && bp_valid && (pc == bp_addr);
`else
    assign bp_hit = 1'b0;
`endif

    assign clr_now   = clr && (state != RUN);
    assign exec      = ((state == RUN) || (state == STEP)) && !clr_now && !bp_hit;
    assign sum_a     = {1'b0, reg_a} + {1'b0, imm};
    assign sum_b     = {1'b0, reg_b} + {1'b0, imm};
    assign halt_cond = exec && jump && (target == pc);

    // Decode and execute the instruction at pc, or clear the core.
    always_comb begin
        a_n   = reg_a;
        b_n   = reg_b;
        out_n = out_port;
        pc_n  = pc;
        c_n   = carry;
        jump  = 1'b0;
        if (clr_now) begin
            a_n   = '0;
            b_n   = '0;
            out_n = '0;
            pc_n  = '0;
            c_n   = 1'b0;
        end else if (exec) begin
            c_n  = 1'b0;
            pc_n = pc + ADDR_W'(1);
            unique case (op)
                4'b0000: {c_n, a_n} = sum_a;
                4'b0001: a_n = reg_b;
                4'b0010: a_n = in_port;
                4'b0011: a_n = imm;
                4'b0100: b_n = reg_a;
                4'b0101: {c_n, b_n} = sum_b;
                4'b0110: b_n = in_port;
                4'b0111: b_n = imm;
                4'b1001: out_n = reg_b;
                4'b1011: out_n = imm;
                4'b1110: jump = !carry;
                4'b1111: jump = 1'b1;
                default: ;
            endcase
            if (jump) pc_n = target;
        end
    end

    // Run-control next state; leaving EXEC always returns to IDLE.
    always_comb begin
        state_n = state;
        if (!exec_mode) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE, HALT: begin
                    if (stop)       state_n = state;
                    else if (step)  state_n = STEP;
                    else if (start) state_n = RUN;
                end
                RUN: begin
                    if (stop)                     state_n = IDLE;
                    else if (halt_cond || bp_hit) state_n = HALT;
                end
                STEP: state_n = halt_cond ? HALT : IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    // Run-control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Architectural registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_a    <= '0;
            reg_b    <= '0;
            out_port <= '0;
            pc       <= '0;
            carry    <= 1'b0;
        end else begin
            reg_a    <= a_n;
            reg_b    <= b_n;
            out_port <= out_n;
            pc       <= pc_n;
            carry    <= c_n;
        end
    end

    // Program RAM; reset leaves every word as ADD A,0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
        end else if (load_we) begin
            ram[prog_addr] <= {prog_imm, prog_op};
        end
    end

endmodule

// File: tb/tb_td4x_core.sv
// tb_td4x_core: scoreboard bench for td4x_core against an ISA-level model.
// Breakpoint stimulus is included when TD4X_BREAKPOINT_EN is defined.
module tb_td4x_core;
    localparam int DW = 4;
    localparam int AW = 4;
    localparam int DEPTH = 1 << AW;
    localparam int MD = 1 << DW;
    localparam int MA = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    mode;
    logic [AW-1:0] prog_addr;
    logic [3:0]    prog_op;
    logic [DW-1:0] prog_imm;
    logic          prog_we;
    logic [3:0]    rd_op;
    logic [DW-1:0] rd_imm;
    logic          start, step, stop, clr;
    logic [DW-1:0] in_port, out_port, reg_a, reg_b;
    logic [AW-1:0] pc;
    logic          carry;
    logic [1:0]    run_state;
    logic [AW-1:0] bp_addr;
    logic          bp_valid;

    td4x_core #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .prog_addr(prog_addr), .prog_op(prog_op),
        .prog_imm(prog_imm), .prog_we(prog_we),
        .rd_op(rd_op), .rd_imm(rd_imm),
        .start(start), .step(step), .stop(stop), .clr(clr),
        .in_port(in_port), .out_port(out_port),
        .reg_a(reg_a), .reg_b(reg_b), .pc(pc),
        .carry(carry), .run_state(run_state)
`ifdef TD4X_BREAKPOINT_EN
        , .bp_addr(bp_addr), .bp_valid(bp_valid)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int a, b, o, p, c, st, rop, rim;
    } exp_t;

    exp_t sb[$];
    int n_chk = 0;
    int n_fail = 0;

    // ISA-level model state
    int ma, mb, mo, mpc, mc, mst;
    int rop[DEPTH];
    int rim[DEPTH];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ma = 0; mb = 0; mo = 0; mpc = 0; mc = 0; mst = 0;
        for (int i = 0; i < DEPTH; i++) begin
            rop[i] = 0;
            rim[i] = 0;
        end
    endtask

    // One clock edge of the architecture, from current inputs.
    task automatic model_step();
        int op, im, tgt, s, nst, npc, nc;
        bit running, clear, bp, jmp, halt;
        exp_t e;
        running = (mst == 1) || (mst == 2);
        clear = clr && (mst != 1);
        bp = 0;
`ifdef TD4X_BREAKPOINT_EN
        bp = (mst == 1) && bp_valid && (mpc == int'(bp_addr));
`endif
        op = rop[mpc];
        im = rim[mpc];
        tgt = im % MA;
        jmp = 0;
        halt = 0;
        if (clear) begin
            ma = 0; mb = 0; mo = 0; mpc = 0; mc = 0;
        end else if (running && !bp) begin
            npc = (mpc + 1) % MA;
            nc = 0;
            case (op)
                0:  begin s = ma + im; nc = (s >= MD); ma = s % MD; end
                1:  ma = mb;
                2:  ma = int'(in_port);
                3:  ma = im;
                4:  mb = ma;
                5:  begin s = mb + im; nc = (s >= MD); mb = s % MD; end
                6:  mb = int'(in_port);
                7:  mb = im;
                9:  mo = mb;
                11: mo = im;
                14: jmp = (mc == 0);
                15: jmp = 1;
                default: ;
            endcase
            halt = jmp && (tgt == mpc);
            mpc = jmp ? tgt : npc;
            mc = nc;
        end
        nst = mst;
        if (mode < 2) nst = 0;
        else if (mst == 0 || mst == 3) begin
            if (stop) nst = mst;
            else if (step) nst = 2;
            else if (start) nst = 1;
        end else if (mst == 1) begin
            if (stop) nst = 0;
            else if (halt || bp) nst = 3;
        end else begin
            nst = halt ? 3 : 0;
        end
        mst = nst;
        if (mode == 0 && prog_we) begin
            rop[prog_addr] = int'(prog_op);
            rim[prog_addr] = int'(prog_imm);
        end
        e.a = ma; e.b = mb; e.o = mo; e.p = mpc; e.c = mc; e.st = mst;
        e.rop = rop[prog_addr];
        e.rim = rim[prog_addr];
        sb.push_back(e);
    endtask

    // Monitor: compares DUT state after every edge that had stimulus.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_reg_a", int'(reg_a), e.a);
                chk("sb_reg_b", int'(reg_b), e.b);
                chk("sb_out", int'(out_port), e.o);
                chk("sb_pc", int'(pc), e.p);
                chk("sb_carry", int'(carry), e.c);
                chk("sb_state", int'(run_state), e.st);
                chk("sb_rd_op", int'(rd_op), e.rop);
                chk("sb_rd_imm", int'(rd_imm), e.rim);
            end
        end
    end

    // Drive one cycle at a negedge; inp < 0 picks a random IN value.
    task automatic drive(input int md, input bit st, input bit sp,
                         input bit stp, input bit cl, input int inp);
        mode = 2'(md);
        start = st;
        step = sp;
        stop = stp;
        clr = cl;
        in_port = (inp < 0) ? DW'($urandom) : DW'(inp);
        model_step();
        @(negedge clk);
        start = 0; step = 0; stop = 0; clr = 0;
    endtask

    task automatic load(input int addr, input int op, input int im);
        prog_addr = AW'(addr);
        prog_op = 4'(op);
        prog_imm = DW'(im);
        prog_we = 1;
        drive(0, 0, 0, 0, 0, -1);
        prog_we = 0;
    endtask

    task automatic step_one(input int inp);
        drive(2, 0, 1, 0, 0, inp);
        drive(2, 0, 0, 0, 0, inp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(2, 0, 0, 0, 0, -1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_a"}, int'(reg_a), 0);
        chk({tag, "_b"}, int'(reg_b), 0);
        chk({tag, "_out"}, int'(out_port), 0);
        chk({tag, "_pc"}, int'(pc), 0);
        chk({tag, "_carry"}, int'(carry), 0);
        chk({tag, "_state"}, int'(run_state), 0);
    endtask

    initial begin
        int op, r;
        rst_n = 0; mode = 0; prog_addr = 0; prog_op = 0; prog_imm = 0;
        prog_we = 0; start = 0; step = 0; stop = 0; clr = 0;
        in_port = 0; bp_addr = 0; bp_valid = 0;
        model_reset();
        #2;
        check_zero("rst");
        mode = 1;
        for (int i = 0; i < DEPTH; i += 5) begin
            prog_addr = AW'(i);
            #1;
            chk("rst_rd_op", int'(rd_op), 0);
            chk("rst_rd_imm", int'(rd_imm), 0);
        end
        @(negedge clk);
        rst_n = 1;

        // A=3, A+=5, JMP 2 (self) -> halt
        load(0, 4'b0011, 3);
        load(1, 4'b0000, 5);
        load(2, 4'b1111, 2);
        drive(2, 1, 0, 0, 0, -1);
        idle(4);
        chk("prog1_a", int'(reg_a), 8);
        chk("prog1_carry", int'(carry), 0);
        chk("prog1_pc", int'(pc), 2);
        chk("prog1_halt", int'(run_state), 3);
        drive(2, 1, 0, 0, 0, -1);
        idle(2);
        chk("rerun_halt", int'(run_state), 3);
        chk("rerun_pc", int'(pc), 2);

        // Carry and JNC not taken, via single steps
        drive(2, 0, 0, 0, 1, -1);
        chk("clr_pc", int'(pc), 0);
        load(0, 4'b0011, 14);
        load(1, 4'b0000, 3);
        load(2, 4'b1110, 5);
        load(3, 4'b1000, 0);
        drive(2, 0, 1, 0, 0, -1);
        chk("step_state", int'(run_state), 2);
        drive(2, 0, 0, 0, 0, -1);
        chk("step_idle", int'(run_state), 0);
        chk("step_pc", int'(pc), 1);
        step_one(-1);
        chk("add_wrap_a", int'(reg_a), 1);
        chk("add_carry", int'(carry), 1);
        step_one(-1);
        chk("jnc_nt_pc", int'(pc), 3);
        chk("jnc_carry", int'(carry), 0);

        // Free run then stop: pc holds afterwards
        drive(2, 1, 0, 0, 0, -1);
        idle(3);
        drive(2, 0, 0, 1, 0, -1);
        idle(2);
        chk("stop_state", int'(run_state), 0);
        chk("stop_pc", int'(pc), 7);

        // IN/OUT and pc wrap
        drive(2, 0, 0, 0, 1, -1);
        load(0, 4'b0010, 0);
        load(1, 4'b0110, 0);
        load(2, 4'b1001, 0);
        load(3, 4'b1111, 15);
        load(15, 4'b1000, 0);
        step_one(9);
        chk("in_a", int'(reg_a), 9);
        step_one(6);
        step_one(0);
        chk("out_b", int'(out_port), 6);
        step_one(0);
        chk("jmp_pc", int'(pc), 15);
        step_one(0);
        chk("wrap_pc", int'(pc), 0);

        // Asynchronous reset in the middle of a run
        drive(2, 1, 0, 0, 0, -1);
        idle(2);
        #2;
        rst_n = 0;
        #1;
        model_reset();
        check_zero("midrst");
        prog_addr = 1;
        #1;
        chk("midrst_rd", int'(rd_op), 0);
        @(negedge clk);
        rst_n = 1;

        // Random programs and random run control
        for (int i = 0; i < DEPTH; i++) begin
            r = $urandom_range(0, 15);
            op = (r == 12) ? 4'b1111 : r;
            load(i, op, $urandom);
        end
        for (int i = 0; i < 800; i++) begin
            bp_valid = ($urandom_range(0, 3) == 0);
            bp_addr = AW'($urandom);
            r = $urandom_range(0, 99);
            if (r < 4) begin
                prog_addr = AW'($urandom);
                prog_op = 4'($urandom);
                prog_imm = DW'($urandom);
                prog_we = $urandom_range(0, 1);
                drive($urandom_range(0, 1), 0, 0, 0, 0, -1);
                prog_we = 0;
            end else begin
                prog_addr = AW'($urandom);
                drive($urandom_range(2, 3),
                      $urandom_range(0, 9) == 0,
                      $urandom_range(0, 9) == 0,
                      $urandom_range(0, 19) == 0,
                      $urandom_range(0, 19) == 0, -1);
            end
        end
        bp_valid = 0;
        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
